// File: rtl/uart_pkg.sv
// Shared types for the parameterised UART receiver: parity modes, receiver
// states and the depth of the line synchronizer.
package uart_pkg;

  typedef enum logic [1:0] {
    PAR_NONE,
    PAR_EVEN,
    PAR_ODD
  } parity_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_REARM
  } rx_state_t;

  localparam int SYNC_STAGES = 2;

endpackage

// File: rtl/uart_rx_fifo.sv
// Show-ahead receive FIFO: the head word sits in a register that is refreshed
// from the array (or bypassed from the write port) whenever the head moves.
module uart_rx_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg, rd_ptr_reg, rd_ptr_next;
  logic [PTR_W:0]   count_reg;
  logic [WIDTH-1:0] rd_data_reg;
  logic             do_wr, do_rd;

  assign full        = (count_reg == (PTR_W + 1)'(DEPTH));
  assign empty       = (count_reg == '0);
  assign do_rd       = rd_en && !empty;
  assign do_wr       = wr_en && (!full || do_rd);
  assign rd_ptr_next = do_rd ? rd_ptr_reg + 1'b1 : rd_ptr_reg;
  assign rd_data     = rd_data_reg;

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr_reg] <= wr_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_reg  <= '0;
      rd_ptr_reg  <= '0;
      count_reg   <= '0;
      rd_data_reg <= '0;
    end else begin
      if (do_wr) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      rd_ptr_reg <= rd_ptr_next;
      count_reg  <= count_reg + (PTR_W + 1)'(do_wr) - (PTR_W + 1)'(do_rd);
      // A write landing on the next head slot is not yet readable from the array.
      if (do_wr && (wr_ptr_reg == rd_ptr_next))
        rd_data_reg <= wr_data;
      else if (do_rd && (count_reg != (PTR_W + 1)'(1)))
        rd_data_reg <= mem[rd_ptr_next];
    end
  end

endmodule

// File: rtl/uart_rx_param.sv
// Parameterised UART receiver: oversampling-free mid-bit sampling FSM feeding
// a show-ahead FIFO of {data, parity_err, frame_err} words.
module uart_rx_param
  import uart_pkg::*;
#(
  parameter int      CLK_FREQ_HZ = 50_000_000,
  parameter int      BAUD        = 9600,
  parameter int      DATA_BITS   = 8,
  parameter parity_t PARITY      = PAR_NONE,
  parameter int      STOP_BITS   = 1,
  parameter int      FIFO_DEPTH  = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 io_rx,
  input  logic                 io_data_ready,
  output logic                 io_data_valid,
  output logic [DATA_BITS-1:0] io_data_packet,
  output logic                 io_parity_err,
  output logic                 io_frame_err,
  output logic                 io_overrun
);

  localparam int BIT_TICKS  = CLK_FREQ_HZ / BAUD;
  localparam int HALF_TICKS = BIT_TICKS / 2;
  localparam int CNT_W      = $clog2(BIT_TICKS + 1);
  localparam int BIT_W      = $clog2(DATA_BITS + 1);
  localparam int WORD_W     = DATA_BITS + 2;

  logic [SYNC_STAGES-1:0] sync_reg;
  logic                   rx_s;
  rx_state_t              state_reg, state_next;
  logic [CNT_W-1:0]       cnt_reg, cnt_next;
  logic [BIT_W-1:0]       bit_reg, bit_next;
  logic [DATA_BITS-1:0]   data_reg, data_next;
  logic                   par_err_reg, par_err_next;
  logic                   frm_err_reg, frm_err_next;
  logic                   push_reg, push_next;
  logic [WORD_W-1:0]      word_reg, word_next;
  logic                   overrun_reg;
  logic                   bit_done;
  logic [WORD_W-1:0]      head_word;
  logic                   fifo_full, fifo_empty;

  assign rx_s     = sync_reg[SYNC_STAGES-1];
  assign bit_done = (cnt_reg == CNT_W'(BIT_TICKS - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_reg    <= '1;
      state_reg   <= ST_REARM;
      cnt_reg     <= '0;
      bit_reg     <= '0;
      data_reg    <= '0;
      par_err_reg <= 1'b0;
      frm_err_reg <= 1'b0;
      push_reg    <= 1'b0;
      word_reg    <= '0;
      overrun_reg <= 1'b0;
    end else begin
      sync_reg    <= {sync_reg[SYNC_STAGES-2:0], io_rx};
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      bit_reg     <= bit_next;
      data_reg    <= data_next;
      par_err_reg <= par_err_next;
      frm_err_reg <= frm_err_next;
      push_reg    <= push_next;
      word_reg    <= word_next;
      overrun_reg <= push_reg && fifo_full && !(io_data_ready && io_data_valid);
    end
  end

  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    bit_next     = bit_reg;
    data_next    = data_reg;
    par_err_next = par_err_reg;
    frm_err_next = frm_err_reg;
    push_next    = 1'b0;
    word_next    = word_reg;
    case (state_reg)
      ST_IDLE: begin
        if (!rx_s) begin
          state_next = ST_START;
          cnt_next   = '0;
        end
      end
      ST_START: begin
        if (cnt_reg == CNT_W'(HALF_TICKS - 1)) begin
          cnt_next     = '0;
          bit_next     = '0;
          par_err_next = 1'b0;
          frm_err_next = 1'b0;
          state_next   = rx_s ? ST_IDLE : ST_DATA;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      ST_DATA: begin
        if (bit_done) begin
          cnt_next  = '0;
          data_next = {rx_s, data_reg[DATA_BITS-1:1]};
          if (bit_reg == BIT_W'(DATA_BITS - 1)) begin
            bit_next   = '0;
            state_next = (PARITY == PAR_NONE) ? ST_STOP : ST_PARITY;
          end else begin
            bit_next = bit_reg + 1'b1;
          end
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      ST_PARITY: begin
        if (bit_done) begin
          cnt_next     = '0;
          par_err_next = ((^data_reg) ^ rx_s) != (PARITY == PAR_ODD);
          state_next   = ST_STOP;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      ST_STOP: begin
        if (bit_done) begin
          cnt_next = '0;
          if (bit_reg == BIT_W'(STOP_BITS - 1)) begin
            bit_next   = '0;
            push_next  = 1'b1;
            word_next  = {data_reg, par_err_reg, frm_err_reg | ~rx_s};
            state_next = rx_s ? ST_IDLE : ST_REARM;
          end else begin
            frm_err_next = frm_err_reg | ~rx_s;
            bit_next     = bit_reg + 1'b1;
          end
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      ST_REARM: begin
        // Hold until the synchronizer has flushed its reset value, so a line
        // stuck low across reset is never mistaken for a high.
        if (cnt_reg != CNT_W'(SYNC_STAGES)) begin
          cnt_next = cnt_reg + 1'b1;
        end else if (rx_s) begin
          cnt_next   = '0;
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_REARM;
    endcase
  end

  uart_rx_fifo #(
    .WIDTH(WORD_W),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .reset  (reset),
    .wr_en  (push_reg),
    .wr_data(word_reg),
    .rd_en  (io_data_ready),
    .rd_data(head_word),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

  assign io_data_valid  = !fifo_empty;
  assign io_data_packet = head_word[WORD_W-1:2];
  assign io_parity_err  = head_word[1];
  assign io_frame_err   = head_word[0];
  assign io_overrun     = overrun_reg;

endmodule

// File: tb/tb_uart_rx_param.sv
// Directed-plus-random bench for uart_rx_param: an 8N1 and an 8E1 receiver
// driven with serial frames and compared with a word-level reference model.
module tb_uart_rx_param;
  import uart_pkg::*;

  localparam int BT = 10;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rx_n = 1'b1, rx_e = 1'b1;
  logic       rdy_n = 1'b0, rdy_e = 1'b0;
  logic       vld_n, vld_e, perr_n, perr_e, ferr_n, ferr_e, ovr_n, ovr_e;
  logic [7:0] pkt_n, pkt_e;
  int         n_pass = 0;
  int         n_checks = 0;
  int         ovr_cnt_n = 0;
  logic [9:0] exp_q[$];

  always #5 clk = ~clk;

  uart_rx_param #(
    .CLK_FREQ_HZ(1_000_000), .BAUD(100_000), .DATA_BITS(8),
    .PARITY(PAR_NONE), .STOP_BITS(1), .FIFO_DEPTH(4)
  ) dut_n (
    .clk(clk), .reset(reset), .io_rx(rx_n), .io_data_ready(rdy_n),
    .io_data_valid(vld_n), .io_data_packet(pkt_n), .io_parity_err(perr_n),
    .io_frame_err(ferr_n), .io_overrun(ovr_n)
  );

  uart_rx_param #(
    .CLK_FREQ_HZ(1_000_000), .BAUD(100_000), .DATA_BITS(8),
    .PARITY(PAR_EVEN), .STOP_BITS(1), .FIFO_DEPTH(4)
  ) dut_e (
    .clk(clk), .reset(reset), .io_rx(rx_e), .io_data_ready(rdy_e),
    .io_data_valid(vld_e), .io_data_packet(pkt_e), .io_parity_err(perr_e),
    .io_frame_err(ferr_e), .io_overrun(ovr_e)
  );

  always @(negedge clk) if (ovr_n) ovr_cnt_n <= ovr_cnt_n + 1;

  // Expected word {data, parity_err, frame_err}; even parity wants an even
  // total count of ones over data plus parity bit.
  function automatic logic [9:0] model_word(input logic [7:0] d, input logic par_en,
                                            input logic pbit, input logic stop);
    logic perr;
    perr = par_en ? ((($countones(d) + int'(pbit)) % 2) == 1) : 1'b0;
    return {d, perr, ~stop};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_rx(input logic sel, input logic v);
    if (sel) rx_e = v; else rx_n = v;
  endtask

  task automatic send_frame(input logic sel, input logic [7:0] d, input logic pbit, input logic stop);
    logic [10:0] bits;
    int nb;
    if (sel) begin bits = {stop, pbit, d, 1'b0}; nb = 11; end
    else     begin bits = {1'b0, stop, d, 1'b0}; nb = 10; end
    for (int i = 0; i < nb; i++) begin
      set_rx(sel, bits[i]);
      idle(BT);
    end
    set_rx(sel, 1'b1);
  endtask

  task automatic check_head(input logic sel, input logic [9:0] w, input string tag);
    logic v, pe, fe;
    logic [7:0] p;
    if (sel) begin v = vld_e; p = pkt_e; pe = perr_e; fe = ferr_e; end
    else     begin v = vld_n; p = pkt_n; pe = perr_n; fe = ferr_n; end
    check({tag, ".valid"}, 32'(v), 32'd1);
    check({tag, ".data"}, 32'(p), 32'(w[9:2]));
    check({tag, ".perr"}, 32'(pe), 32'(w[1]));
    check({tag, ".ferr"}, 32'(fe), 32'(w[0]));
    $display("word %s: data=0x%0h perr=%0d ferr=%0d", tag, p, pe, fe);
  endtask

  task automatic pop(input logic sel);
    if (sel) rdy_e = 1'b1; else rdy_n = 1'b1;
    idle(1);
    rdy_e = 1'b0;
    rdy_n = 1'b0;
  endtask

  initial begin
    logic [7:0] d;
    logic       p;
    logic [9:0] w;
    int         ovr_base;

    #1;
    check("rst.valid_n", 32'(vld_n), 32'd0);
    check("rst.data_n", 32'(pkt_n), 32'd0);
    check("rst.perr_n", 32'(perr_n), 32'd0);
    check("rst.ferr_n", 32'(ferr_n), 32'd0);
    check("rst.ovr_n", 32'(ovr_n), 32'd0);
    check("rst.valid_e", 32'(vld_e), 32'd0);
    check("rst.data_e", 32'(pkt_e), 32'd0);
    check("rst.perr_e", 32'(perr_e), 32'd0);
    check("rst.ferr_e", 32'(ferr_e), 32'd0);
    check("rst.ovr_e", 32'(ovr_e), 32'd0);
    idle(5);
    reset = 1'b0;
    idle(10);

    send_frame(1'b0, 8'hA5, 1'b0, 1'b1);
    idle(3);
    check_head(1'b0, model_word(8'hA5, 1'b0, 1'b0, 1'b1), "a5");
    pop(1'b0);
    check("a5.empty", 32'(vld_n), 32'd0);

    for (int k = 0; k < 4; k++) begin
      d = 8'($urandom_range(0, 255));
      send_frame(1'b0, d, 1'b0, 1'b1);
      idle(3);
      check_head(1'b0, model_word(d, 1'b0, 1'b0, 1'b1), "rand8n1");
      pop(1'b0);
    end

    send_frame(1'b1, 8'h03, 1'b1, 1'b1);
    idle(3);
    check_head(1'b1, model_word(8'h03, 1'b1, 1'b1, 1'b1), "par_bit1");
    pop(1'b1);
    send_frame(1'b1, 8'h03, 1'b0, 1'b1);
    idle(3);
    check_head(1'b1, model_word(8'h03, 1'b1, 1'b0, 1'b1), "par_bit0");
    pop(1'b1);
    for (int k = 0; k < 4; k++) begin
      d = 8'($urandom_range(0, 255));
      p = 1'($urandom_range(0, 1));
      send_frame(1'b1, d, p, 1'b1);
      idle(3);
      check_head(1'b1, model_word(d, 1'b1, p, 1'b1), "rand8e1");
      pop(1'b1);
    end
    check("par.empty", 32'(vld_e), 32'd0);

    // Break: line low for 30 bit-times gives exactly one framing-error word.
    set_rx(1'b0, 1'b0);
    idle(105);
    check_head(1'b0, model_word(8'h00, 1'b0, 1'b0, 1'b0), "break");
    pop(1'b0);
    idle(194);
    check("break.no_more", 32'(vld_n), 32'd0);
    set_rx(1'b0, 1'b1);
    idle(20);
    d = 8'($urandom_range(0, 255));
    send_frame(1'b0, d, 1'b0, 1'b1);
    idle(3);
    check_head(1'b0, model_word(d, 1'b0, 1'b0, 1'b1), "after_break");
    pop(1'b0);

    // Short glitch on the line must be rejected.
    set_rx(1'b0, 1'b0);
    idle(3);
    set_rx(1'b0, 1'b1);
    idle(40);
    check("glitch.no_push", 32'(vld_n), 32'd0);
    d = 8'($urandom_range(0, 255));
    send_frame(1'b0, d, 1'b0, 1'b1);
    idle(3);
    check_head(1'b0, model_word(d, 1'b0, 1'b0, 1'b1), "after_glitch");
    pop(1'b0);

    // Overrun: five words into a four-deep buffer with nobody reading.
    ovr_base = ovr_cnt_n;
    for (int k = 0; k < 5; k++) begin
      d = 8'($urandom_range(0, 255));
      send_frame(1'b0, d, 1'b0, 1'b1);
      idle(2);
      if (exp_q.size() < 4) exp_q.push_back(model_word(d, 1'b0, 1'b0, 1'b1));
      if (k == 3) check("ovr.before_fifth", 32'(ovr_cnt_n - ovr_base), 32'd0);
    end
    idle(3);
    check("ovr.pulses", 32'(ovr_cnt_n - ovr_base), 32'd1);
    while (exp_q.size() > 0) begin
      w = exp_q.pop_front();
      check_head(1'b0, w, "fifo_order");
      pop(1'b0);
    end
    check("fifo.drained", 32'(vld_n), 32'd0);

    // Reset in the middle of a frame with the line held low.
    send_frame(1'b0, 8'hC3, 1'b0, 1'b1);
    idle(3);
    check("pre_rst.valid", 32'(vld_n), 32'd1);
    set_rx(1'b0, 1'b0);
    idle(40);
    reset = 1'b1;
    #1;
    check("mid_rst.valid", 32'(vld_n), 32'd0);
    check("mid_rst.data", 32'(pkt_n), 32'd0);
    check("mid_rst.perr", 32'(perr_n), 32'd0);
    check("mid_rst.ferr", 32'(ferr_n), 32'd0);
    check("mid_rst.ovr", 32'(ovr_n), 32'd0);
    idle(3);
    reset = 1'b0;
    idle(30);
    check("post_rst.low_line", 32'(vld_n), 32'd0);
    set_rx(1'b0, 1'b1);
    idle(20);
    check("post_rst.no_word", 32'(vld_n), 32'd0);
    d = 8'($urandom_range(0, 255));
    send_frame(1'b0, d, 1'b0, 1'b1);
    idle(3);
    check_head(1'b0, model_word(d, 1'b0, 1'b0, 1'b1), "post_rst");
    pop(1'b0);
    check("post_rst.empty", 32'(vld_n), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
